// File: rtl/forno_controle_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forno_controle_param_pkg
//  Description : Shared constants for the parametrised microwave controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package forno_controle_param_pkg;

    localparam int unsigned c_BCD_W   = 4;
    localparam logic [3:0]  c_KEY_MAX = 4'd9;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ENTRY  = 3'd1;
    localparam logic [2:0] c_ST_COOK   = 3'd2;
    localparam logic [2:0] c_ST_PAUSED = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/forno_controle_param_bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : forno_controle_param_bcd_time_counter
//  Description : Packed BCD mm..:ss buffer with digit shift-in and a
//                one-second decrement (59 wrap, rippling minute borrow).
//  Revision    : 1.0 - initial release
// ============================================================================
module forno_controle_param_bcd_time_counter
    import forno_controle_param_pkg::*;
#(
    parameter int MIN_DIGITS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_clr_buf,
    input  logic                                   i_shift_en,
    input  logic [3:0]                             i_digit,
    input  logic                                   i_dec_en,
    output logic [c_BCD_W*(MIN_DIGITS+2)-1:0]      o_value,
    output logic                                   o_zero,
    output logic                                   o_last
);

    localparam int c_W = c_BCD_W * (MIN_DIGITS + 2);

    logic [c_W-1:0] r_value;
    logic [c_W-1:0] w_dec;
    logic           w_borrow;

    always_comb begin
        w_dec    = r_value;
        w_borrow = 1'b1;
        if (r_value[3:0] != 4'd0) begin
            w_dec[3:0] = r_value[3:0] - 4'd1;
        end else if (r_value[7:4] != 4'd0) begin
            w_dec[7:4] = r_value[7:4] - 4'd1;
            w_dec[3:0] = 4'd9;
        end else begin
            // Seconds exhausted: reload 59 and borrow one minute, rippling upward
            w_dec[7:0] = 8'h59;
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (w_borrow) begin
                    if (r_value[8+4*i +: 4] == 4'd0) begin
                        w_dec[8+4*i +: 4] = 4'd9;
                    end else begin
                        w_dec[8+4*i +: 4] = r_value[8+4*i +: 4] - 4'd1;
                        w_borrow          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr_buf) begin
            r_value <= '0;
        end else if (i_shift_en) begin
            r_value <= {r_value[c_W-5:0], i_digit};
        end else if (i_dec_en && !o_zero) begin
            r_value <= w_dec;
        end
    end

    assign o_value = r_value;
    assign o_zero  = (r_value == '0);
    // A value of exactly 1 s means the next decrement lands on zero
    assign o_last  = (r_value == {{(c_W-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/forno_controle_param.sv
`default_nettype none
// ============================================================================
//  Module      : forno_controle_param
//  Description : Microwave controller: keypad time entry, BCD countdown,
//                duty-cycled magnetron with door interlock, pause/resume.
//  Revision    : 1.0 - initial release
// ============================================================================
module forno_controle_param
    import forno_controle_param_pkg::*;
#(
    parameter int MIN_DIGITS  = 2,
    parameter int TICK_DIV    = 50000000,
    parameter int POWER_STEPS = 10,
    parameter int DONE_SECS   = 3
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          door_closed,
    input  logic [3:0]                    power_sel,
    output logic [4*(MIN_DIGITS+2)-1:0]   bcd_out,
    output logic                          mag_on,
    output logic                          done,
    output logic [2:0]                    state_out
);

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_PW    = $clog2(POWER_STEPS + 1);
    localparam int c_DW    = (DONE_SECS > 1) ? $clog2(DONE_SECS) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX   = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_PW-1:0]    c_PH_MAX    = c_PW'(POWER_STEPS - 1);
    localparam logic [c_PW-1:0]    c_PWR_FULL  = c_PW'(POWER_STEPS);
    localparam logic [c_DW-1:0]    c_DONE_LAST = c_DW'(DONE_SECS - 1);

    logic [2:0]         r_state;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_PW-1:0]    r_phase;
    logic [c_PW-1:0]    r_power;
    logic [c_DW-1:0]    r_dcnt;

    logic               w_tick;
    logic               w_key_ok;
    logic               w_start_ok;
    logic               w_zero;
    logic               w_last;
    logic               w_shift;
    logic               w_clr_buf;
    logic               w_dec;
    logic [c_PW-1:0]    w_power_sel;

    assign w_tick     = (r_presc == c_PRE_MAX);
    assign w_key_ok   = key_valid && (key_code <= c_KEY_MAX);
    assign w_start_ok = start && door_closed && !w_zero;
    // Out-of-range or zero power selects full power
    assign w_power_sel = ((power_sel == 4'd0) || ({28'd0, power_sel} > 32'(POWER_STEPS)))
                         ? c_PWR_FULL : c_PW'(power_sel);

    always_comb begin
        w_shift   = 1'b0;
        w_clr_buf = 1'b0;
        w_dec     = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_shift = w_key_ok;
            c_ST_ENTRY: begin
                if (stop)             w_clr_buf = 1'b1;
                else if (!w_start_ok) w_shift   = w_key_ok;
            end
            c_ST_COOK:   w_dec     = door_closed && !stop && w_tick;
            c_ST_PAUSED: w_clr_buf = stop;
            default: ;
        endcase
    end

    forno_controle_param_bcd_time_counter #(
        .MIN_DIGITS (MIN_DIGITS)
    ) u_time (
        .clk        (clk),
        .rst        (clear),
        .i_clr_buf  (w_clr_buf),
        .i_shift_en (w_shift),
        .i_digit    (key_code),
        .i_dec_en   (w_dec),
        .o_value    (bcd_out),
        .o_zero     (w_zero),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_ST_IDLE;
            r_presc <= '0;
            r_phase <= '0;
            r_power <= '0;
            r_dcnt  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_key_ok) r_state <= c_ST_ENTRY;
                end
                c_ST_ENTRY: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_start_ok) begin
                        r_state <= c_ST_COOK;
                        r_presc <= '0;
                        r_phase <= '0;
                        r_power <= w_power_sel;
                    end
                end
                c_ST_COOK: begin
                    if (!door_closed || stop) begin
                        r_state <= c_ST_PAUSED;
                    end else if (w_tick) begin
                        r_phase <= (r_phase == c_PH_MAX) ? '0 : r_phase + 1'b1;
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            r_dcnt  <= '0;
                        end
                    end
                end
                c_ST_PAUSED: begin
                    if (stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (start && door_closed) begin
                        r_state <= c_ST_COOK;
                        r_presc <= '0;
                        r_power <= w_power_sel;
                    end
                end
                c_ST_DONE: begin
                    if (!door_closed || stop || key_valid) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_tick) begin
                        if (r_dcnt == c_DONE_LAST) r_state <= c_ST_IDLE;
                        else                       r_dcnt  <= r_dcnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Door term stays combinational so an opening door cuts power immediately
    assign mag_on    = (r_state == c_ST_COOK) && door_closed && (r_phase < r_power);
    assign done      = (r_state == c_ST_DONE);
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: doc/forno_controle_param.md
Name: forno_controle_param

Overview:
Parametrised successor to the single-configuration microwave controller. It merges keypad time entry, the min/sec countdown, power-level duty-cycled magnetron control and pause/resume into one FSM-driven block.
- Outputs packed BCD digits for the existing 7-segment decoders.
- Outputs a door-interlocked mag_on.
- Sits between debounced front-panel inputs and the display/magnetron drivers.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (time = MIN_DIGITS minute digits + 2 second digits)
TICK_DIV, 50000000, clk cycles per 1 s tick
POWER_STEPS, 10, seconds per duty-cycle window; also the maximum power level
DONE_SECS, 3, ticks the done flag stays high before auto-return to IDLE

Ports:
clk  in  1  system clock
clear  in  1  synchronous active-high reset
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; values >9 ignored
start  in  1  one-cycle start/resume strobe
stop  in  1  one-cycle stop/cancel strobe
door_closed  in  1  level, 1 = door closed
power_sel  in  4  power level; 0 or >POWER_STEPS treated as POWER_STEPS
bcd_out  out  4*(MIN_DIGITS+2)  packed BCD, [3:0] = sec ones, [7:4] = sec tens, upward = minutes
mag_on  out  1  magnetron enable
done  out  1  cook-complete indicator
state_out  out  3  current FSM state for debug/LEDs

Behaviour:
- One clock, clk. clear is synchronous, active-high, and overrides every other input.
- On clear: state IDLE; bcd_out all 0; mag_on 0; done 0; prescaler, duty phase and latched power all 0.
- Prescaler: counts 0..TICK_DIV-1 and pulses an internal tick when it wraps. It is forced to 0 on every entry to COOK, so the first decrement occurs TICK_DIV cycles after start.
- States: IDLE, ENTRY, COOK, PAUSED, DONE.
- IDLE:
  - A valid digit shifts left into the BCD buffer (new digit into sec ones; the MS minute digit is discarded) -> ENTRY.
  - start and stop are ignored.
- ENTRY:
  - Further digits shift in the same way.
  - stop clears the buffer -> IDLE.
  - start with door_closed=1 and a nonzero buffer latches power and zeroes the duty phase -> COOK.
  - start with a zero buffer or an open door is ignored.
- Entry value is taken literally; seconds digits up to 99 are legal.
- COOK decrement, on each tick:
  - sec ones > 0: decrement sec ones.
  - Else sec tens > 0: sec tens - 1, sec ones = 9.
  - Else (both 0): borrow from minutes (BCD decrement with ripple), seconds = 59.
  - When the result is 00..00: -> DONE in the same cycle; the buffer reads zero.
- COOK exits:
  - door_closed=0 -> PAUSED.
  - stop -> PAUSED. Pending ticks are not applied.
- Duty phase: counts 0..POWER_STEPS-1 on each tick in COOK and wraps. It is held in PAUSED.
- mag_on = (state==COOK) & door_closed & (phase < latched power). The door_closed term is combinational, so an opening door drops mag_on in that same cycle.
- PAUSED:
  - start with door_closed=1 -> COOK; the prescaler resets and phase is kept.
  - stop clears the buffer -> IDLE.
  - Keys are ignored.
- DONE:
  - done=1.
  - After DONE_SECS ticks -> IDLE with done=0.
  - Any key, stop, or door opening -> IDLE immediately; the key is not shifted in.
- Priority in one cycle: clear > door open > stop > start > key > tick. A tick coinciding with a stop or door event does not decrement.
- state_out encoding: IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4.
- power_sel is sampled only at the start/resume transition.

Decomposition:
- Shared package: state encoding constants, key-code limit (9), BCD digit width (4).
- Sub-module bcd_time_counter:
  - Parametrised on MIN_DIGITS.
  - Provides shift-in, clear and tick-decrement with 59 wrap and minute borrow.
  - Provides a zero flag.
- FSM, prescaler and duty logic stay in the top.

Test Plan:
- Entry and countdown, TICK_DIV=4, MIN_DIGITS=2: clear, keys 1,0,5, start, door closed -> bcd_out shows 01:05 (01 min 05 s). After 4 cycles it shows 01:04. After 65 ticks it reaches 00:00 and the state is DONE with done=1. After DONE_SECS further ticks the state is IDLE with done=0.
- Minute borrow: enter 2,0,0 and start -> the first tick gives 01:59. Entering 9,9 gives 00:99 and the first tick gives 00:98.
- Door interlock: drop door_closed mid-COOK -> mag_on is 0 in the same cycle, state_out=3 and the count is frozen. Close the door and start -> COOK resumes and the first decrement comes TICK_DIV cycles later.
- Power duty: power_sel=3, POWER_STEPS=10, 20 s cook -> mag_on is high for ticks 0-2 of each 10-tick window (6 of 20 s). power_sel=0 -> mag_on stays high continuously.
- Ignored or priority inputs:
  - start with a zero buffer -> stays IDLE.
  - start with door open in ENTRY -> stays ENTRY.
  - stop and start in the same cycle in COOK -> PAUSED.
  - stop in PAUSED -> IDLE with a zero buffer.
  - key_code=12 -> no shift.
- Reset mid-cook: assert clear during COOK with mag_on=1 -> next cycle all outputs are 0 and state_out=0. A start while clear is held has no effect.
